saturn_bus_sequencer: RTL and testbench
=======================================

# saturn_bus_sequencer

Sequences and arbitrates the Saturn nibble bus for three requesters: instruction fetch, data access (DP read/write) and bus-management commands (CONFIGURE, BUS_RESET). It turns each granted request into the correct command/address/data nibble stream on the bus pins. It then restores PC_READ streaming so fetch resumes without CPU involvement. It sits between the CPU core and the external bus pins.

## Interface
- No parameters.
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_en  in  1  bus slot enable. Only cycles with i_en=1 advance state or the bus.
- i_fetch_ready  in  1  fetch consumer can take a nibble this slot
- i_jump  in  1  request to reload the bus PC pointer with i_jump_addr
- i_jump_addr  in  20  new PC
- o_jump_ack  out  1  one-cycle pulse when the jump is granted
- o_fetch_valid  out  1  o_fetch_nibble holds a fetched nibble (one cycle)
- o_fetch_nibble  out  4  fetched nibble
- i_data_req  in  1  data transfer request
- i_data_we  in  1  1 = write, 0 = read
- i_data_addr  in  20  DP address
- i_data_len  in  4  transfer length minus 1 (1..16 nibbles)
- o_data_ack  out  1  one-cycle pulse when the request is latched
- i_data_wnib  in  4  write nibble, consumed on o_data_wtake
- o_data_wtake  out  1  the current write nibble is put on the bus this slot
- o_data_rvalid  out  1  o_data_rnib is valid (one cycle)
- o_data_rnib  out  4  read nibble
- i_cfg_req, i_cfg_addr[19:0]  in  CONFIGURE request and its address
- i_busreset_req  in  1  BUS_RESET request
- o_mgmt_ack  out  1  one-cycle pulse when a cfg or bus-reset request is granted
- o_busy  out  1  a non-fetch transaction is in progress (CPU stall source)
- i_bus_data  in  4  bus read data
- o_bus_data  out  4  bus drive nibble
- o_bus_strobe  out  1  nibble-transfer strobe
- o_bus_cmd_data  out  1  0 = command/address nibble, 1 = data nibble or idle

## Operation
- Command codes come from def-buscmd.v: PC_READ=0, DP_READ=1, DP_WRITE=3, LOAD_PC=4, LOAD_DP=5, CONFIGURE=6, BUS_RESET=A.
- States:
  - BOOT: issues LOAD_PC 00000 after reset.
  - FETCH: streams PC_READ.
  - CMD: one command nibble, cmd_data=0.
  - ADDR: 5 address nibbles, LSB nibble first, cmd_data=0.
  - WCMD: DP_WRITE command nibble.
  - XFER: len+1 data nibbles, cmd_data=1.
  - RESTORE: a single PC_READ command nibble.
- Grants are made only from FETCH, at slot boundaries.
- Priority: bus-reset > data > cfg > jump > fetch streaming. A losing request stays pending; requesters hold their request until acked.
- Jump: CMD(LOAD_PC) → ADDR(jump_addr) → FETCH. Bus modules enter PC_READ automatically after the LOAD_PC address, so no RESTORE follows.
- Data read: CMD(LOAD_DP) → ADDR → XFER(read) → RESTORE → FETCH. Modules enter DP_READ automatically.
- Data write: CMD(LOAD_DP) → ADDR → WCMD → XFER(write) → RESTORE → FETCH.
- CONFIGURE: CMD → ADDR(cfg_addr) → RESTORE → FETCH.
- BUS_RESET: CMD → RESTORE → FETCH.
- FETCH: strobe in each enabled slot where i_fetch_ready=1. With i_fetch_ready=0, no strobe and the bus PC does not advance.
- Reads: the nibble strobed in slot k is sampled from i_bus_data in slot k+1. It appears on o_fetch_nibble or o_data_rnib with a valid pulse, so strobes pipeline back-to-back. A read completing while the state is already RESTORE still delivers its nibble.
- Writes: o_bus_data = i_data_wnib with strobe=1 and o_data_wtake=1 in the same slot.
- Length counter is 4 bits, loaded with i_data_len, and decremented per data strobe. XFER ends at count 0, so i_data_len=F gives 16 nibbles.
- The address nibble counter runs 0..4; address nibble n is addr[4n+3:4n].
- o_busy = 1 in every state except FETCH, from the ack cycle through the RESTORE slot. It is also 1 in BOOT.

## Timing
- Reset values:
  - o_bus_data 0, o_bus_strobe 0, o_bus_cmd_data 1.
  - All acks and valids 0, o_busy 1, state BOOT, pending flags cleared.
- Outputs are registered and change only on edges with i_en=1. The exception is the ack/valid/wtake pulses, which are cleared on the next edge regardless of i_en.
- Every command and address nibble has strobe=1.
- Jump latency: ack in slot 0 (LOAD_PC on bus), address slots 1–5, first fetch strobe in slot 6.
- Read of N nibbles: 1 + 5 + N strobe slots, then RESTORE. The last rvalid coincides with the RESTORE slot.
- Write of N nibbles: 1 + 5 + 1 + N slots, then RESTORE.
- i_reset mid-transaction: on the next edge the block drops the transaction, pending requests and in-flight reads, and returns to BOOT.
- i_en=0 for any number of cycles freezes the sequence exactly; no slot is lost or duplicated.

## Structure
- Bus command constants live in def-buscmd.v; state encodings go in a new def-bus-seq.v.
- One sub-module: saturn_bus_addr_ser, a 20-bit to 5×4-bit LSB-first serializer with load/shift/done.
- Arbitration logic, length counter and read-return pipeline stay in saturn_bus_sequencer.

## Test plan
- Reset then i_fetch_ready=1:
  - bus shows cmd 4 followed by 0,0,0,0,0 with cmd_data=0.
  - Then PC_READ strobes with cmd_data=1.
  - fetch nibbles arrive one slot after each strobe.
- Read (addr=12345, len=2): bus shows 5,5,4,3,2,1 then three data strobes. Three rvalid pulses occur, the restore nibble 0 has cmd_data=0, and o_busy falls after it.
- Write (addr=00010, len=0, wnib=A): bus shows 5,0,1,0,0,0 then 3 then A with o_data_wtake. PC_READ (0) follows.
- Same-cycle i_busreset_req, i_data_req and i_jump:
  - The bus-reset (A) goes first.
  - The data transfer follows, then the jump.
  - Each is acked exactly once.
- i_cfg_req (addr=F0000) with i_en toggling 1010… produces nibbles 6,0,0,0,0,F then 0, identical in content to the run with i_en=1.
- i_reset asserted during data XFER:
  - Next cycle o_bus_cmd_data=1 and strobe=0, with no further rvalid.
  - BOOT LOAD_PC 00000 is then reissued.

Source files
------------

// File: rtl/saturn_bus_sequencer_pkg.sv
// Shared definitions for the Saturn nibble-bus sequencer:
// bus command codes, sequencer states, transaction kinds.
package saturn_bus_sequencer_pkg;

  localparam logic [3:0] CMD_PC_READ   = 4'h0;
  localparam logic [3:0] CMD_DP_READ   = 4'h1;
  localparam logic [3:0] CMD_DP_WRITE  = 4'h3;
  localparam logic [3:0] CMD_LOAD_PC   = 4'h4;
  localparam logic [3:0] CMD_LOAD_DP   = 4'h5;
  localparam logic [3:0] CMD_CONFIGURE = 4'h6;
  localparam logic [3:0] CMD_BUS_RESET = 4'hA;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_CMD,
    S_ADDR,
    S_WCMD,
    S_XFER,
    S_RESTORE
  } seq_state_t;

  typedef enum logic [2:0] {
    K_JUMP,
    K_READ,
    K_WRITE,
    K_CFG,
    K_BRST
  } xact_kind_t;

  typedef struct packed {
    logic [3:0] data;
    logic       strobe;
    logic       cmd_data;
  } bus_out_t;

  function automatic logic [3:0] kind_cmd(input xact_kind_t k);
    logic [3:0] c;
    c = CMD_LOAD_PC;
    case (k)
      K_READ, K_WRITE: c = CMD_LOAD_DP;
      K_CFG:           c = CMD_CONFIGURE;
      K_BRST:          c = CMD_BUS_RESET;
      default:         c = CMD_LOAD_PC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/saturn_bus_sequencer_if.sv
// Saturn nibble-bus pins: master drives data/strobe/cmd_data,
// slave side returns i_bus_data.
interface saturn_bus_sequencer_if;
  logic [3:0] i_bus_data;
  logic [3:0] o_bus_data;
  logic       o_bus_strobe;
  logic       o_bus_cmd_data;

  modport master (
    input  i_bus_data,
    output o_bus_data,
    output o_bus_strobe,
    output o_bus_cmd_data
  );

  modport slave (
    output i_bus_data,
    input  o_bus_data,
    input  o_bus_strobe,
    input  o_bus_cmd_data
  );
endinterface

// File: rtl/saturn_bus_addr_ser.sv
// 20-bit address to 5 x 4-bit serializer, LSB nibble first.
// Ports: load/addr, shift, current nibble, next nibble, done (index 4).
module saturn_bus_addr_ser (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [19:0] i_addr,
  input  logic        i_shift,
  output logic [3:0]  o_nib,
  output logic [3:0]  o_nib_next,
  output logic        o_done
);

  logic [19:0] sh;
  logic [2:0]  idx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh  <= '0;
      idx <= '0;
    end else if (i_load) begin
      sh  <= i_addr;
      idx <= '0;
    end else if (i_shift) begin
      sh  <= {4'h0, sh[19:4]};
      idx <= idx + 3'd1;
    end
  end

  assign o_nib      = sh[3:0];
  assign o_nib_next = sh[7:4];
  assign o_done     = (idx == 3'd4);

endmodule

// File: rtl/saturn_bus_sequencer.sv
// Arbitrates fetch/data/management requests onto the Saturn nibble bus.
// Ports: CPU-side request/ack/data, bus pins via saturn_bus_sequencer_if.
module saturn_bus_sequencer
  import saturn_bus_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_fetch_ready,
  input  logic        i_jump,
  input  logic [19:0] i_jump_addr,
  output logic        o_jump_ack,
  output logic        o_fetch_valid,
  output logic [3:0]  o_fetch_nibble,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [19:0] i_data_addr,
  input  logic [3:0]  i_data_len,
  output logic        o_data_ack,
  input  logic [3:0]  i_data_wnib,
  output logic        o_data_wtake,
  output logic        o_data_rvalid,
  output logic [3:0]  o_data_rnib,
  input  logic        i_cfg_req,
  input  logic [19:0] i_cfg_addr,
  input  logic        i_busreset_req,
  output logic        o_mgmt_ack,
  output logic        o_busy,
  saturn_bus_sequencer_if.master bus
);

  seq_state_t state, state_nx;
  xact_kind_t kind, kind_nx;

  logic [3:0] len_cnt;
  logic pend_brst, pend_data, pend_cfg, pend_jump;
  logic eff_brst, eff_data, eff_cfg, eff_jump;
  logic g_brst, g_data, g_cfg, g_jump, grant;
  logic rd_f, rd_d;

  bus_out_t bus_nx;
  logic busy_nx, wtake_nx, rd_f_nx, rd_d_nx;

  logic        ser_load, ser_shift, ser_done;
  logic [19:0] ser_addr;
  logic [3:0]  ser_nib, ser_nib_next;

  // A request still visible during its own ack cycle is already served.
  assign eff_brst = pend_brst | (i_busreset_req & ~o_mgmt_ack);
  assign eff_data = pend_data | (i_data_req & ~o_data_ack);
  assign eff_cfg  = pend_cfg | (i_cfg_req & ~o_mgmt_ack);
  assign eff_jump = pend_jump | (i_jump & ~o_jump_ack);

  assign g_brst = (state == S_FETCH) & eff_brst;
  assign g_data = (state == S_FETCH) & eff_data & ~eff_brst;
  assign g_cfg  = (state == S_FETCH) & eff_cfg & ~eff_brst & ~eff_data;
  assign g_jump = (state == S_FETCH) & eff_jump
                & ~eff_brst & ~eff_data & ~eff_cfg;
  assign grant  = g_brst | g_data | g_cfg | g_jump;

  assign ser_load  = i_en & ((state == S_BOOT) | grant);
  assign ser_shift = i_en & (state == S_ADDR) & ~ser_done;
  assign ser_addr  = g_data ? i_data_addr
                   : g_cfg  ? i_cfg_addr
                   : g_jump ? i_jump_addr
                   : 20'h0;

  saturn_bus_addr_ser u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ser_load),
    .i_addr     (ser_addr),
    .i_shift    (ser_shift),
    .o_nib      (ser_nib),
    .o_nib_next (ser_nib_next),
    .o_done     (ser_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_BOOT;
      kind  <= K_JUMP;
    end else if (i_en) begin
      state <= state_nx;
      kind  <= kind_nx;
    end
  end

  always_comb begin
    state_nx = state;
    kind_nx  = kind;
    unique case (state)
      S_BOOT: begin
        state_nx = S_CMD;
        kind_nx  = K_JUMP;
      end
      S_FETCH: begin
        if (grant) begin
          state_nx = S_CMD;
          unique case (1'b1)
            g_brst:  kind_nx = K_BRST;
            g_data:  kind_nx = i_data_we ? K_WRITE : K_READ;
            g_cfg:   kind_nx = K_CFG;
            default: kind_nx = K_JUMP;
          endcase
        end
      end
      S_CMD:
        state_nx = (kind == K_BRST) ? S_RESTORE : S_ADDR;
      S_ADDR: begin
        if (ser_done) begin
          unique case (kind)
            K_JUMP:  state_nx = S_FETCH;
            K_READ:  state_nx = S_XFER;
            K_WRITE: state_nx = S_WCMD;
            default: state_nx = S_RESTORE;
          endcase
        end
      end
      S_WCMD:
        state_nx = S_XFER;
      S_XFER:
        if (len_cnt == 4'h0) state_nx = S_RESTORE;
      S_RESTORE:
        state_nx = S_FETCH;
      default:
        state_nx = S_BOOT;
    endcase
  end

  // Values the bus shows in the slot that starts at this edge.
  always_comb begin
    bus_nx   = '{data: 4'h0, strobe: 1'b0, cmd_data: 1'b1};
    wtake_nx = 1'b0;
    rd_f_nx  = 1'b0;
    rd_d_nx  = 1'b0;
    busy_nx  = (state_nx != S_FETCH);
    unique case (state_nx)
      S_FETCH: begin
        bus_nx.strobe = i_fetch_ready;
        rd_f_nx       = i_fetch_ready;
      end
      S_CMD:
        bus_nx = '{data: kind_cmd(kind_nx), strobe: 1'b1,
                   cmd_data: 1'b0};
      S_ADDR:
        bus_nx = '{data: (state == S_ADDR) ? ser_nib_next : ser_nib,
                   strobe: 1'b1, cmd_data: 1'b0};
      S_WCMD:
        bus_nx = '{data: CMD_DP_WRITE, strobe: 1'b1, cmd_data: 1'b0};
      S_XFER: begin
        bus_nx.strobe = 1'b1;
        if (kind_nx == K_WRITE) begin
          bus_nx.data = i_data_wnib;
          wtake_nx    = 1'b1;
        end else begin
          rd_d_nx = 1'b1;
        end
      end
      S_RESTORE:
        bus_nx = '{data: CMD_PC_READ, strobe: 1'b1, cmd_data: 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_bus_data     <= 4'h0;
      bus.o_bus_strobe   <= 1'b0;
      bus.o_bus_cmd_data <= 1'b1;
      o_busy             <= 1'b1;
      o_jump_ack         <= 1'b0;
      o_data_ack         <= 1'b0;
      o_mgmt_ack         <= 1'b0;
      o_fetch_valid      <= 1'b0;
      o_fetch_nibble     <= 4'h0;
      o_data_rvalid      <= 1'b0;
      o_data_rnib        <= 4'h0;
      o_data_wtake       <= 1'b0;
      pend_brst          <= 1'b0;
      pend_data          <= 1'b0;
      pend_cfg           <= 1'b0;
      pend_jump          <= 1'b0;
      len_cnt            <= 4'h0;
      rd_f               <= 1'b0;
      rd_d               <= 1'b0;
    end else begin
      o_jump_ack    <= 1'b0;
      o_data_ack    <= 1'b0;
      o_mgmt_ack    <= 1'b0;
      o_fetch_valid <= 1'b0;
      o_data_rvalid <= 1'b0;
      o_data_wtake  <= 1'b0;
      if (i_en) begin
        bus.o_bus_data     <= bus_nx.data;
        bus.o_bus_strobe   <= bus_nx.strobe;
        bus.o_bus_cmd_data <= bus_nx.cmd_data;
        o_busy             <= busy_nx;
        o_data_wtake       <= wtake_nx;
        rd_f               <= rd_f_nx;
        rd_d               <= rd_d_nx;
        o_jump_ack         <= g_jump;
        o_data_ack         <= g_data;
        o_mgmt_ack         <= g_brst | g_cfg;
        pend_brst          <= eff_brst & ~g_brst;
        pend_data          <= eff_data & ~g_data;
        pend_cfg           <= eff_cfg & ~g_cfg;
        pend_jump          <= eff_jump & ~g_jump;
        if (g_data)
          len_cnt <= i_data_len;
        else if (state == S_XFER && len_cnt != 4'h0)
          len_cnt <= len_cnt - 4'h1;
        // Nibble strobed last slot is returned now.
        if (rd_f) begin
          o_fetch_valid  <= 1'b1;
          o_fetch_nibble <= bus.i_bus_data;
        end
        if (rd_d) begin
          o_data_rvalid <= 1'b1;
          o_data_rnib   <= bus.i_bus_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Directed self-checking bench for saturn_bus_sequencer:
// boot, fetch, read, write, arbitration, i_en stalls, reset.
module tb_saturn_bus_sequencer;

  logic        clk;
  logic        i_reset, i_en, i_fetch_ready;
  logic        i_jump;
  logic [19:0] i_jump_addr;
  logic        o_jump_ack, o_fetch_valid;
  logic [3:0]  o_fetch_nibble;
  logic        i_data_req, i_data_we;
  logic [19:0] i_data_addr;
  logic [3:0]  i_data_len, i_data_wnib;
  logic        o_data_ack, o_data_wtake, o_data_rvalid;
  logic [3:0]  o_data_rnib;
  logic        i_cfg_req;
  logic [19:0] i_cfg_addr;
  logic        i_busreset_req, o_mgmt_ack, o_busy;

  saturn_bus_sequencer_if bus ();

  saturn_bus_sequencer dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_en           (i_en),
    .i_fetch_ready  (i_fetch_ready),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .o_jump_ack     (o_jump_ack),
    .o_fetch_valid  (o_fetch_valid),
    .o_fetch_nibble (o_fetch_nibble),
    .i_data_req     (i_data_req),
    .i_data_we      (i_data_we),
    .i_data_addr    (i_data_addr),
    .i_data_len     (i_data_len),
    .o_data_ack     (o_data_ack),
    .i_data_wnib    (i_data_wnib),
    .o_data_wtake   (o_data_wtake),
    .o_data_rvalid  (o_data_rvalid),
    .o_data_rnib    (o_data_rnib),
    .i_cfg_req      (i_cfg_req),
    .i_cfg_addr     (i_cfg_addr),
    .i_busreset_req (i_busreset_req),
    .o_mgmt_ack     (o_mgmt_ack),
    .o_busy         (o_busy),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int nj = 0;
  int nd = 0;
  int nm = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] d,
                         input logic s, input logic c);
    chk(tag, {26'd0, bus.o_bus_data, bus.o_bus_strobe,
              bus.o_bus_cmd_data}, {26'd0, d, s, c});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic stepc;
    step();
    nj += int'(o_jump_ack);
    nd += int'(o_data_ack);
    nm += int'(o_mgmt_ack);
  endtask

  initial begin
    logic [3:0] rn [5];
    logic [3:0] wn [5];
    logic [3:0] cn [5];
    logic [3:0] dn [5];
    logic [3:0] jn [5];
    rn = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    wn = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    cn = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    dn = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    jn = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};

    i_reset = 1'b1; i_en = 1'b1; i_fetch_ready = 1'b0;
    i_jump = 1'b0; i_jump_addr = '0;
    i_data_req = 1'b0; i_data_we = 1'b0; i_data_addr = '0;
    i_data_len = '0; i_data_wnib = '0;
    i_cfg_req = 1'b0; i_cfg_addr = '0; i_busreset_req = 1'b0;
    bus.i_bus_data = 4'h0;

    // reset state
    step(); step();
    chk_bus("rst_bus", 4'h0, 1'b0, 1'b1);
    chk("rst_busy", 32'(o_busy), 32'd1);
    chk("rst_pulses", {26'd0, o_jump_ack, o_data_ack, o_mgmt_ack,
        o_fetch_valid, o_data_rvalid, o_data_wtake}, 32'd0);

    // boot LOAD_PC 00000
    i_reset = 1'b0; i_fetch_ready = 1'b1;
    step();
    chk_bus("boot_cmd", 4'h4, 1'b1, 1'b0);
    chk("boot_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bus("boot_addr", 4'h0, 1'b1, 1'b0);
    end

    // PC_READ streaming
    step();
    chk_bus("fetch_strobe", 4'h0, 1'b1, 1'b1);
    chk("fetch_busy", 32'(o_busy), 32'd0);
    bus.i_bus_data = 4'h7;
    step();
    chk("fetch_v1", 32'(o_fetch_valid), 32'd1);
    chk("fetch_n1", 32'(o_fetch_nibble), 32'h7);
    bus.i_bus_data = 4'h9;
    step();
    chk("fetch_n2", 32'(o_fetch_nibble), 32'h9);
    i_fetch_ready = 1'b0;
    step();
    chk_bus("fetch_stall", 4'h0, 1'b0, 1'b1);
    chk("fetch_v3", 32'(o_fetch_valid), 32'd1);
    step();
    chk("fetch_v4", 32'(o_fetch_valid), 32'd0);
    i_fetch_ready = 1'b1;

    // data read addr 12345 len 2
    i_data_req = 1'b1; i_data_we = 1'b0;
    i_data_addr = 20'h12345; i_data_len = 4'h2;
    step();
    chk("rd_ack", 32'(o_data_ack), 32'd1);
    chk_bus("rd_cmd", 4'h5, 1'b1, 1'b0);
    chk("rd_busy", 32'(o_busy), 32'd1);
    i_data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bus("rd_addr", rn[i], 1'b1, 1'b0);
    end
    step();
    chk_bus("rd_x0", 4'h0, 1'b1, 1'b1);
    chk("rd_v0", 32'(o_data_rvalid), 32'd0);
    bus.i_bus_data = 4'h1;
    step();
    chk_bus("rd_x1", 4'h0, 1'b1, 1'b1);
    chk("rd_n1", {27'd0, o_data_rvalid, o_data_rnib}, 32'h11);
    bus.i_bus_data = 4'h2;
    step();
    chk_bus("rd_x2", 4'h0, 1'b1, 1'b1);
    chk("rd_n2", {27'd0, o_data_rvalid, o_data_rnib}, 32'h12);
    bus.i_bus_data = 4'h3;
    step();
    chk_bus("rd_restore", 4'h0, 1'b1, 1'b0);
    chk("rd_n3", {27'd0, o_data_rvalid, o_data_rnib}, 32'h13);
    chk("rd_busy_rst", 32'(o_busy), 32'd1);
    step();
    chk("rd_busy_end", 32'(o_busy), 32'd0);
    chk("rd_v_end", 32'(o_data_rvalid), 32'd0);
    chk_bus("rd_fetch", 4'h0, 1'b1, 1'b1);

    // data write addr 00010 len 0 wnib A
    i_data_req = 1'b1; i_data_we = 1'b1;
    i_data_addr = 20'h00010; i_data_len = 4'h0; i_data_wnib = 4'hA;
    step();
    chk("wr_ack", 32'(o_data_ack), 32'd1);
    chk_bus("wr_cmd", 4'h5, 1'b1, 1'b0);
    i_data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bus("wr_addr", wn[i], 1'b1, 1'b0);
    end
    step();
    chk_bus("wr_wcmd", 4'h3, 1'b1, 1'b0);
    chk("wr_wt0", 32'(o_data_wtake), 32'd0);
    step();
    chk_bus("wr_data", 4'hA, 1'b1, 1'b1);
    chk("wr_wt1", 32'(o_data_wtake), 32'd1);
    step();
    chk_bus("wr_restore", 4'h0, 1'b1, 1'b0);
    chk("wr_wt2", 32'(o_data_wtake), 32'd0);
    step();
    chk_bus("wr_fetch", 4'h0, 1'b1, 1'b1);
    chk("wr_busy", 32'(o_busy), 32'd0);

    // same-cycle bus-reset, data read, jump
    i_busreset_req = 1'b1;
    i_data_req = 1'b1; i_data_we = 1'b0;
    i_data_addr = 20'hABCDE; i_data_len = 4'h0;
    i_jump = 1'b1; i_jump_addr = 20'h54321;
    nj = 0; nd = 0; nm = 0;
    stepc();
    chk("arb_mack", {29'd0, o_mgmt_ack, o_data_ack, o_jump_ack}, 32'h4);
    chk_bus("arb_brst", 4'hA, 1'b1, 1'b0);
    i_busreset_req = 1'b0;
    stepc();
    chk_bus("arb_brst_rst", 4'h0, 1'b1, 1'b0);
    stepc();
    chk_bus("arb_fetch1", 4'h0, 1'b1, 1'b1);
    stepc();
    chk("arb_dack", {29'd0, o_mgmt_ack, o_data_ack, o_jump_ack}, 32'h2);
    chk_bus("arb_dcmd", 4'h5, 1'b1, 1'b0);
    i_data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepc();
      chk_bus("arb_daddr", dn[i], 1'b1, 1'b0);
    end
    stepc();
    chk_bus("arb_dx", 4'h0, 1'b1, 1'b1);
    stepc();
    chk_bus("arb_drst", 4'h0, 1'b1, 1'b0);
    stepc();
    chk_bus("arb_fetch2", 4'h0, 1'b1, 1'b1);
    stepc();
    chk("arb_jack", {29'd0, o_mgmt_ack, o_data_ack, o_jump_ack}, 32'h1);
    chk_bus("arb_jcmd", 4'h4, 1'b1, 1'b0);
    i_jump = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepc();
      chk_bus("arb_jaddr", jn[i], 1'b1, 1'b0);
    end
    stepc();
    chk_bus("arb_fetch3", 4'h0, 1'b1, 1'b1);
    chk("arb_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 4; i++) stepc();
    chk("arb_nm", nm, 1);
    chk("arb_nd", nd, 1);
    chk("arb_nj", nj, 1);

    // CONFIGURE F0000 with i_en toggling 1010...
    i_cfg_req = 1'b1; i_cfg_addr = 20'hF0000;
    i_en = 1'b1;
    step();
    chk("cfg_ack", 32'(o_mgmt_ack), 32'd1);
    chk_bus("cfg_cmd", 4'h6, 1'b1, 1'b0);
    i_cfg_req = 1'b0;
    i_en = 1'b0;
    step();
    chk("cfg_ack_clr", 32'(o_mgmt_ack), 32'd0);
    chk_bus("cfg_cmd_hold", 4'h6, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      i_en = 1'b1;
      step();
      chk_bus("cfg_addr", cn[i], 1'b1, 1'b0);
      i_en = 1'b0;
      step();
      chk_bus("cfg_addr_hold", cn[i], 1'b1, 1'b0);
    end
    i_en = 1'b1;
    step();
    chk_bus("cfg_restore", 4'h0, 1'b1, 1'b0);
    i_en = 1'b0;
    step();
    chk_bus("cfg_restore_hold", 4'h0, 1'b1, 1'b0);
    chk("cfg_busy_hold", 32'(o_busy), 32'd1);
    i_en = 1'b1;
    step();
    chk_bus("cfg_fetch", 4'h0, 1'b1, 1'b1);
    chk("cfg_busy", 32'(o_busy), 32'd0);

    // reset during a 16-nibble read
    i_data_req = 1'b1; i_data_we = 1'b0;
    i_data_addr = 20'h00000; i_data_len = 4'hF;
    step();
    chk("rr_ack", 32'(o_data_ack), 32'd1);
    i_data_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    step();
    chk_bus("rr_x0", 4'h0, 1'b1, 1'b1);
    bus.i_bus_data = 4'h5;
    step();
    chk("rr_n1", {27'd0, o_data_rvalid, o_data_rnib}, 32'h15);
    i_reset = 1'b1;
    step();
    chk_bus("rr_rst_bus", 4'h0, 1'b0, 1'b1);
    chk("rr_rst_v", 32'(o_data_rvalid), 32'd0);
    chk("rr_rst_busy", 32'(o_busy), 32'd1);
    i_reset = 1'b0;
    step();
    chk_bus("rr_boot_cmd", 4'h4, 1'b1, 1'b0);
    chk("rr_boot_v", 32'(o_data_rvalid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bus("rr_boot_addr", 4'h0, 1'b1, 1'b0);
    end
    step();
    chk_bus("rr_fetch", 4'h0, 1'b1, 1'b1);
    chk("rr_busy", 32'(o_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
